bp_cacc_io_csr: RTL and testbench
=================================

// Module: bp_cacc_io_csr
// PURPOSE
//  Host-facing memory-mapped CSR front end for a cache-coherent accelerator (CACC) compute datapath.
//  Accepts uncached read/write IO commands from the network, buffers them, and decodes them into
//  the accelerator configuration registers. Issues a start pulse to the downstream compute FSM,
//  tracks busy/done, and returns one IO response per command with a valid/yumi handshake.
// PARAMETERS
//  addr_width_p     40  IO command address width
//  payload_width_p  16  opaque header payload, echoed in response
//  max_len_p        8   max vector length the datapath supports; len CSR clamps to this
//  len_width_p      4   width of len_o (>= $clog2(max_len_p+1))
// PORTS
//  clk_i            in   1              clock
//  reset_i          in   1              synchronous, active-high reset
//  io_cmd_v_i       in   1              command valid
//  io_cmd_ready_o   out  1              command ready (bsg_two_fifo ready)
//  io_cmd_wr_i      in   1              1=uncached write, 0=uncached read
//  io_cmd_addr_i    in   addr_width_p   byte address; low 20 bits are the CSR offset
//  io_cmd_size_i    in   3              request size, echoed
//  io_cmd_payload_i in   payload_width_p  echoed
//  io_cmd_data_i    in   64             write data
//  io_resp_v_o      out  1              response valid
//  io_resp_yumi_i   in   1              response consumed
//  io_resp_wr_o     out  1              echo of command type
//  io_resp_addr_o / io_resp_size_o / io_resp_payload_o  out  (as cmd)  echoed header
//  io_resp_data_o   out  64             read data; 0 for writes
//  a_ptr_o, b_ptr_o, res_ptr_o  out 64  operand/result base addresses
//  len_o            out  len_width_p    clamped vector length
//  op_o             out  64             operation select
//  start_o          out  1              one-cycle start pulse to compute FSM
//  done_i           in   1              one-cycle completion pulse from compute FSM
// BEHAVIOUR
//  - Reset: all CSRs 0, busy=0, done=0, op_count=0, start_o=0, io_resp_v_o=0, FIFO empty.
//  - Cmd accepted on io_cmd_v_i & io_cmd_ready_o into 2-entry FIFO. Head processed when FIFO
//    valid and response slot empty; head dequeued that cycle, response registered.
//  - Latency: accept at cycle t -> io_resp_v_o high at t+2 (no backpressure). Response held,
//    stable, until io_resp_yumi_i; slot frees same cycle, so a new head may load at the yumi edge.
//  - FSM: IDLE (slot empty) -> RESP (slot full) on head processed; RESP -> IDLE on yumi with no
//    valid head, RESP -> RESP on yumi with valid head (back-to-back, 1 resp/cycle).
//  - CSR map (offset): 0x000 a_ptr, 0x040 b_ptr, 0x080 len, 0x0c0 start(WO, reads 0),
//    0x100 status(RO: bit0 done, bit1 busy), 0x140 res_ptr, 0x180 res_len, 0x200 op,
//    0x1c0 op_count(RO, 32b zero-extended).
//  - Unmapped offsets: writes dropped, reads return 0; response always sent. Writes to RO CSRs dropped.
//  - Config writes (a_ptr,b_ptr,len,res_ptr,res_len,op) ignored while busy=1; response still sent.
//  - len write: len_o = (data > max_len_p) ? max_len_p : data[len_width_p-1:0] (full 64b compare).
//  - Start write with data[0]=1 and busy=0: start_o=1 next cycle, busy<=1, done<=0. Any start
//    write while busy=1, or data[0]=0: no effect.
//  - done_i while busy=1: busy<=0, done<=1, op_count<=op_count+1 (wraps 2^32-1 -> 0).
//    done_i while busy=0: ignored. Start and done are evaluated against registered busy.
//  - Read data sampled at processing cycle (reflects state before that cycle's updates).
//  - Reset mid-operation: busy/done cleared, pending FIFO entries and held response discarded.
// STRUCTURE
//  - bp_cacc_pkg: CSR offset localparams/enum (bp_cacc_csr_e), status bit positions.
//  - Sub-module: bsg_two_fifo for command buffer (width = 1+addr+3+payload+64).
//  - Single always_ff for CSRs + response register; small 2-state FSM enum local to module.
// TESTING
//  - Write 0x1000 to 0x000, read 0x000 -> resp data 0x1000; resp_v exactly 2 cycles after accept.
//  - Write len 20 -> len_o=8, read 0x080 returns 8; write len 5 -> len_o=5.
//  - Write start=1 -> start_o pulses 1 cycle, status=0x2; write a_ptr while busy -> unchanged;
//    done_i -> status=0x1, op_count=1.
//  - Hold yumi low 10 cycles with 4 cmds issued -> ready_o drops after FIFO full, responses
//    stable, all 4 returned in order with correct payload echo.
//  - Read 0x3f0 -> data 0; start while busy -> no start_o; done_i when idle -> no change.
//  - Assert reset_i while busy with FIFO full -> next cycle resp_v=0, status=0, ready_o=1.

Source files
------------

// File: rtl/bp_cacc_pkg.sv
// bp_cacc_pkg: CSR offsets and status bit positions for the CACC IO CSR block
package bp_cacc_pkg;

    localparam int CSR_OFFSET_WIDTH = 20;
    localparam int STATUS_DONE_BIT  = 0;
    localparam int STATUS_BUSY_BIT  = 1;

    typedef enum logic [CSR_OFFSET_WIDTH-1:0] {
        CSR_A_PTR    = 20'h00000,
        CSR_B_PTR    = 20'h00040,
        CSR_LEN      = 20'h00080,
        CSR_START    = 20'h000c0,
        CSR_STATUS   = 20'h00100,
        CSR_RES_PTR  = 20'h00140,
        CSR_RES_LEN  = 20'h00180,
        CSR_OP_COUNT = 20'h001c0,
        CSR_OP       = 20'h00200
    } bp_cacc_csr_e;

endpackage

// File: rtl/bp_cacc_io_csr_fifo.sv
// bsg_two_fifo: 2-entry valid/ready in, valid/yumi out buffer
//   clk_i, reset_i      clock, sync active-high reset
//   v_i, data_i, ready_o enqueue side (ready only depends on occupancy)
//   v_o, data_o, yumi_i  dequeue side
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] r_mem [2];
    logic               r_rd;
    logic               r_wr;
    logic [1:0]         r_cnt;
    logic               w_enq;

    assign ready_o = (r_cnt != 2'd2);
    assign v_o     = (r_cnt != 2'd0);
    assign data_o  = r_mem[r_rd];
    assign w_enq   = v_i & ready_o;

    always_ff @(posedge clk_i)
        if (w_enq) r_mem[r_wr] <= data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            r_wr  <= r_wr ^ w_enq;
            r_rd  <= r_rd ^ yumi_i;
            r_cnt <= r_cnt + {1'b0, w_enq} - {1'b0, yumi_i};
        end
    end
endmodule

// File: rtl/bp_cacc_io_csr.sv
// bp_cacc_io_csr: host IO command front end decoding into accelerator CSRs
//   io_cmd_*   buffered uncached read/write commands (2-entry FIFO)
//   io_resp_*  one registered response per command, held until io_resp_yumi_i
//   a_ptr_o, b_ptr_o, res_ptr_o, len_o, op_o  configuration to the datapath
//   start_o / done_i  one-cycle start pulse out, one-cycle completion pulse in
module bp_cacc_io_csr
    import bp_cacc_pkg::*;
#(
    parameter int addr_width_p    = 40,
    parameter int payload_width_p = 16,
    parameter int max_len_p       = 8,
    parameter int len_width_p     = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       io_cmd_v_i,
    output logic                       io_cmd_ready_o,
    input  logic                       io_cmd_wr_i,
    input  logic [addr_width_p-1:0]    io_cmd_addr_i,
    input  logic [2:0]                 io_cmd_size_i,
    input  logic [payload_width_p-1:0] io_cmd_payload_i,
    input  logic [63:0]                io_cmd_data_i,
    output logic                       io_resp_v_o,
    input  logic                       io_resp_yumi_i,
    output logic                       io_resp_wr_o,
    output logic [addr_width_p-1:0]    io_resp_addr_o,
    output logic [2:0]                 io_resp_size_o,
    output logic [payload_width_p-1:0] io_resp_payload_o,
    output logic [63:0]                io_resp_data_o,
    output logic [63:0]                a_ptr_o,
    output logic [63:0]                b_ptr_o,
    output logic [63:0]                res_ptr_o,
    output logic [len_width_p-1:0]     len_o,
    output logic [63:0]                op_o,
    output logic                       start_o,
    input  logic                       done_i
);
    localparam int FIFO_W = 1 + addr_width_p + 3 + payload_width_p + 64;
    localparam logic [len_width_p-1:0] MAX_LEN = len_width_p'(max_len_p);

    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    state_e                       r_state;
    logic [63:0]                  r_a_ptr, r_b_ptr, r_res_ptr, r_res_len, r_op;
    logic [len_width_p-1:0]       r_len;
    logic                         r_busy, r_done, r_start;
    logic [31:0]                  r_op_count;
    logic                         r_resp_wr;
    logic [addr_width_p-1:0]      r_resp_addr;
    logic [2:0]                   r_resp_size;
    logic [payload_width_p-1:0]   r_resp_payload;
    logic [63:0]                  r_resp_data;

    logic                         w_fifo_v;
    logic [FIFO_W-1:0]            w_fifo_data;
    logic                         w_wr;
    logic [addr_width_p-1:0]      w_addr;
    logic [2:0]                   w_size;
    logic [payload_width_p-1:0]   w_payload;
    logic [63:0]                  w_data;
    logic [CSR_OFFSET_WIDTH-1:0]  w_off;
    logic                         w_proc, w_cfg_we, w_start, w_done;
    logic [len_width_p-1:0]       w_len_clamp;
    logic [63:0]                  w_status, w_rdata;

    bsg_two_fifo #(.width_p(FIFO_W)) cmd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (io_cmd_ready_o),
        .data_i  ({io_cmd_wr_i, io_cmd_addr_i, io_cmd_size_i, io_cmd_payload_i, io_cmd_data_i}),
        .v_i     (io_cmd_v_i),
        .v_o     (w_fifo_v),
        .data_o  (w_fifo_data),
        .yumi_i  (w_proc)
    );

    assign {w_wr, w_addr, w_size, w_payload, w_data} = w_fifo_data;
    assign w_off       = w_addr[CSR_OFFSET_WIDTH-1:0];
    // the response slot frees on yumi, so the next head can load in the same cycle
    assign w_proc      = w_fifo_v & ((r_state == ST_IDLE) | io_resp_yumi_i);
    assign w_cfg_we    = w_proc & w_wr & ~r_busy;
    assign w_start     = w_cfg_we & (w_off == CSR_START) & w_data[0];
    assign w_done      = done_i & r_busy;
    assign w_len_clamp = (w_data > 64'(max_len_p)) ? MAX_LEN : w_data[len_width_p-1:0];

    always_comb begin
        w_status = '0;
        w_status[STATUS_DONE_BIT] = r_done;
        w_status[STATUS_BUSY_BIT] = r_busy;
        w_rdata = '0;
        case (w_off)
            CSR_A_PTR:    w_rdata = r_a_ptr;
            CSR_B_PTR:    w_rdata = r_b_ptr;
            CSR_LEN:      w_rdata = 64'(r_len);
            CSR_STATUS:   w_rdata = w_status;
            CSR_RES_PTR:  w_rdata = r_res_ptr;
            CSR_RES_LEN:  w_rdata = r_res_len;
            CSR_OP_COUNT: w_rdata = 64'(r_op_count);
            CSR_OP:       w_rdata = r_op;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state        <= ST_IDLE;
            r_a_ptr        <= '0;
            r_b_ptr        <= '0;
            r_res_ptr      <= '0;
            r_res_len      <= '0;
            r_op           <= '0;
            r_len          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_start        <= 1'b0;
            r_op_count     <= '0;
            r_resp_wr      <= 1'b0;
            r_resp_addr    <= '0;
            r_resp_size    <= '0;
            r_resp_payload <= '0;
            r_resp_data    <= '0;
        end else begin
            r_state <= w_proc ? ST_RESP : (io_resp_yumi_i ? ST_IDLE : r_state);
            r_start <= w_start;
            if (w_start) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (w_done) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_op_count <= r_op_count + 32'd1;
            end
            if (w_cfg_we) begin
                case (w_off)
                    CSR_A_PTR:   r_a_ptr   <= w_data;
                    CSR_B_PTR:   r_b_ptr   <= w_data;
                    CSR_LEN:     r_len     <= w_len_clamp;
                    CSR_RES_PTR: r_res_ptr <= w_data;
                    CSR_RES_LEN: r_res_len <= w_data;
                    CSR_OP:      r_op      <= w_data;
                    default:     ;
                endcase
            end
            if (w_proc) begin
                r_resp_wr      <= w_wr;
                r_resp_addr    <= w_addr;
                r_resp_size    <= w_size;
                r_resp_payload <= w_payload;
                r_resp_data    <= w_wr ? 64'd0 : w_rdata;
            end
        end
    end

    assign io_resp_v_o       = (r_state == ST_RESP);
    assign io_resp_wr_o      = r_resp_wr;
    assign io_resp_addr_o    = r_resp_addr;
    assign io_resp_size_o    = r_resp_size;
    assign io_resp_payload_o = r_resp_payload;
    assign io_resp_data_o    = r_resp_data;
    assign a_ptr_o           = r_a_ptr;
    assign b_ptr_o           = r_b_ptr;
    assign res_ptr_o         = r_res_ptr;
    assign len_o             = r_len;
    assign op_o              = r_op;
    assign start_o           = r_start;
endmodule

// File: tb/tb_bp_cacc_io_csr.sv
// tb_bp_cacc_io_csr: scoreboard bench for the CACC IO CSR front end
module tb_bp_cacc_io_csr;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        io_cmd_v_i = 1'b0;
    logic        io_cmd_ready_o;
    logic        io_cmd_wr_i = 1'b0;
    logic [39:0] io_cmd_addr_i = '0;
    logic [2:0]  io_cmd_size_i = '0;
    logic [15:0] io_cmd_payload_i = '0;
    logic [63:0] io_cmd_data_i = '0;
    logic        io_resp_v_o;
    logic        io_resp_yumi_i = 1'b1;
    logic        io_resp_wr_o;
    logic [39:0] io_resp_addr_o;
    logic [2:0]  io_resp_size_o;
    logic [15:0] io_resp_payload_o;
    logic [63:0] io_resp_data_o;
    logic [63:0] a_ptr_o, b_ptr_o, res_ptr_o, op_o;
    logic [3:0]  len_o;
    logic        start_o;
    logic        done_i = 1'b0;

    typedef struct {
        logic        wr;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [15:0] pl;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;

    always #5 clk = ~clk;

    bp_cacc_io_csr dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .io_cmd_v_i       (io_cmd_v_i),
        .io_cmd_ready_o   (io_cmd_ready_o),
        .io_cmd_wr_i      (io_cmd_wr_i),
        .io_cmd_addr_i    (io_cmd_addr_i),
        .io_cmd_size_i    (io_cmd_size_i),
        .io_cmd_payload_i (io_cmd_payload_i),
        .io_cmd_data_i    (io_cmd_data_i),
        .io_resp_v_o      (io_resp_v_o),
        .io_resp_yumi_i   (io_resp_yumi_i),
        .io_resp_wr_o     (io_resp_wr_o),
        .io_resp_addr_o   (io_resp_addr_o),
        .io_resp_size_o   (io_resp_size_o),
        .io_resp_payload_o(io_resp_payload_o),
        .io_resp_data_o   (io_resp_data_o),
        .a_ptr_o          (a_ptr_o),
        .b_ptr_o          (b_ptr_o),
        .res_ptr_o        (res_ptr_o),
        .len_o            (len_o),
        .op_o             (op_o),
        .start_o          (start_o),
        .done_i           (done_i)
    );

    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (io_resp_v_o && io_resp_yumi_i && !reset_i) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected addr=%h pl=%h", io_resp_addr_o, io_resp_payload_o);
            end else begin
                e = q.pop_front();
                if (io_resp_wr_o !== e.wr || io_resp_addr_o !== e.addr || io_resp_size_o !== e.size ||
                    io_resp_payload_o !== e.pl || io_resp_data_o !== e.data) begin
                    failures++;
                    $display("FAIL resp_pl_%h got wr=%b addr=%h size=%0d pl=%h data=%h want wr=%b addr=%h size=%0d pl=%h data=%h",
                             e.pl, io_resp_wr_o, io_resp_addr_o, io_resp_size_o, io_resp_payload_o, io_resp_data_o,
                             e.wr, e.addr, e.size, e.pl, e.data);
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [39:0] addr, input logic [63:0] data,
                        input logic [15:0] pl, input logic [63:0] exp_d);
        int n = 0;
        @(posedge clk); #1;
        io_cmd_v_i = 1'b1;
        io_cmd_wr_i = wr;
        io_cmd_addr_i = addr;
        io_cmd_size_i = pl[2:0];
        io_cmd_payload_i = pl;
        io_cmd_data_i = data;
        q.push_back('{wr, addr, pl[2:0], pl, exp_d});
        @(negedge clk);
        while (!io_cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout pl=%h ready=%b want 1", pl, io_cmd_ready_o);
        end
        @(posedge clk); #1;
        io_cmd_v_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || io_resp_v_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (io_resp_v_o !== 1'b0) begin failures++; $display("FAIL reset_resp_v got=%b want=0", io_resp_v_o); end
        checks++; if (io_cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", io_cmd_ready_o); end
        checks++; if (start_o !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", start_o); end
        checks++; if ({a_ptr_o, b_ptr_o, res_ptr_o, op_o, len_o} !== '0) begin failures++; $display("FAIL reset_csrs a=%h b=%h r=%h op=%h len=%h want 0", a_ptr_o, b_ptr_o, res_ptr_o, op_o, len_o); end
        send(1'b0, 40'h100, 64'h0, 16'h0100, 64'h0);
        send(1'b0, 40'h1c0, 64'h0, 16'h0101, 64'h0);
        wait_drain();
    endtask

    task automatic test_write_read();
        send(1'b1, 40'h000, 64'h1000, 16'h0011, 64'h0);
        @(negedge clk);
        checks++; if (io_resp_v_o !== 1'b0) begin failures++; $display("FAIL latency_t1 resp_v got=%b want=0", io_resp_v_o); end
        @(negedge clk);
        checks++; if (io_resp_v_o !== 1'b1) begin failures++; $display("FAIL latency_t2 resp_v got=%b want=1", io_resp_v_o); end
        send(1'b0, 40'h000, 64'h0, 16'h0012, 64'h1000);
        wait_drain();
        checks++; if (a_ptr_o !== 64'h1000) begin failures++; $display("FAIL a_ptr_out got=%h want=1000", a_ptr_o); end
    endtask

    task automatic test_len();
        logic [63:0] wv [5] = '{64'd20, 64'd8, 64'd9, 64'h1_0000_0003, 64'd5};
        logic [3:0]  ev [5] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd5};
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 40'h080, wv[i], 16'h0200 + 16'(i), 64'h0);
            send(1'b0, 40'h080, 64'h0, 16'h0210 + 16'(i), 64'(ev[i]));
            wait_drain();
            checks++; if (len_o !== ev[i]) begin failures++; $display("FAIL len_%0d got=%0d want=%0d", i, len_o, ev[i]); end
        end
    endtask

    task automatic test_start_done();
        int s0 = start_cnt;
        send(1'b1, 40'h0c0, 64'h1, 16'h0301, 64'h0);
        wait_drain();
        checks++; if (start_cnt !== s0 + 1) begin failures++; $display("FAIL start_pulse got=%0d want=%0d", start_cnt - s0, 1); end
        send(1'b0, 40'h100, 64'h0, 16'h0302, 64'h2);
        send(1'b1, 40'h000, 64'h2222, 16'h0303, 64'h0);
        send(1'b0, 40'h000, 64'h0, 16'h0304, 64'h1000);
        send(1'b1, 40'h0c0, 64'h1, 16'h0305, 64'h0);
        wait_drain();
        checks++; if (a_ptr_o !== 64'h1000) begin failures++; $display("FAIL busy_a_ptr got=%h want=1000", a_ptr_o); end
        checks++; if (start_cnt !== s0 + 1) begin failures++; $display("FAIL start_while_busy got=%0d want=%0d", start_cnt - s0, 1); end
        pulse_done();
        send(1'b0, 40'h100, 64'h0, 16'h0306, 64'h1);
        send(1'b0, 40'h1c0, 64'h0, 16'h0307, 64'h1);
        wait_drain();
        pulse_done();
        send(1'b1, 40'h0c0, 64'h2, 16'h0308, 64'h0);
        send(1'b0, 40'h100, 64'h0, 16'h0309, 64'h1);
        send(1'b0, 40'h1c0, 64'h0, 16'h030a, 64'h1);
        wait_drain();
        checks++; if (start_cnt !== s0 + 1) begin failures++; $display("FAIL start_bit0_clear got=%0d want=%0d", start_cnt - s0, 1); end
    endtask

    task automatic test_unmapped();
        send(1'b0, 40'h3f0, 64'h0, 16'h0401, 64'h0);
        send(1'b1, 40'h3f0, 64'hdead, 16'h0402, 64'h0);
        send(1'b0, 40'h3f0, 64'h0, 16'h0403, 64'h0);
        send(1'b1, 40'h100, 64'h3, 16'h0404, 64'h0);
        send(1'b0, 40'h100, 64'h0, 16'h0405, 64'h1);
        send(1'b0, 40'h0c0, 64'h0, 16'h0406, 64'h0);
        send(1'b1, 40'h200, 64'h55, 16'h0407, 64'h0);
        send(1'b1, 40'hab_0000_0140, 64'h7777_0000, 16'h0408, 64'h0);
        send(1'b1, 40'h180, 64'h33, 16'h0409, 64'h0);
        send(1'b0, 40'h180, 64'h0, 16'h040a, 64'h33);
        send(1'b1, 40'h040, 64'hbbbb, 16'h040b, 64'h0);
        wait_drain();
        checks++; if (op_o !== 64'h55) begin failures++; $display("FAIL op_out got=%h want=55", op_o); end
        checks++; if (res_ptr_o !== 64'h7777_0000) begin failures++; $display("FAIL res_ptr_out got=%h want=77770000", res_ptr_o); end
        checks++; if (b_ptr_o !== 64'hbbbb) begin failures++; $display("FAIL b_ptr_out got=%h want=bbbb", b_ptr_o); end
    endtask

    task automatic test_back_to_back();
        io_resp_yumi_i = 1'b0;
        fork
            begin
                send(1'b0, 40'h000, 64'h0, 16'ha001, 64'h1000);
                send(1'b0, 40'h200, 64'h0, 16'ha002, 64'h55);
                send(1'b0, 40'h140, 64'h0, 16'ha003, 64'h7777_0000);
                send(1'b0, 40'h080, 64'h0, 16'ha004, 64'h5);
            end
            begin
                int n = 0;
                while (!io_resp_v_o && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) begin
                    @(negedge clk);
                    checks++;
                    if (io_resp_v_o !== 1'b1 || io_resp_payload_o !== 16'ha001 || io_resp_data_o !== 64'h1000) begin
                        failures++;
                        $display("FAIL hold_stable got v=%b pl=%h data=%h want v=1 pl=a001 data=1000",
                                 io_resp_v_o, io_resp_payload_o, io_resp_data_o);
                    end
                end
                checks++; if (io_cmd_ready_o !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b want=0", io_cmd_ready_o); end
                io_resp_yumi_i = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_mid();
        send(1'b1, 40'h0c0, 64'h1, 16'h0501, 64'h0);
        wait_drain();
        io_resp_yumi_i = 1'b0;
        send(1'b0, 40'h100, 64'h0, 16'h0502, 64'h2);
        send(1'b0, 40'h000, 64'h0, 16'h0503, 64'h1000);
        send(1'b0, 40'h040, 64'h0, 16'h0504, 64'hbbbb);
        @(negedge clk);
        checks++; if (io_cmd_ready_o !== 1'b0 || io_resp_v_o !== 1'b1) begin failures++; $display("FAIL pre_reset got ready=%b v=%b want ready=0 v=1", io_cmd_ready_o, io_resp_v_o); end
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        q.delete();
        @(negedge clk);
        checks++; if (io_resp_v_o !== 1'b0) begin failures++; $display("FAIL mid_reset_resp_v got=%b want=0", io_resp_v_o); end
        checks++; if (io_cmd_ready_o !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", io_cmd_ready_o); end
        checks++; if (a_ptr_o !== 64'h0) begin failures++; $display("FAIL mid_reset_a_ptr got=%h want=0", a_ptr_o); end
        io_resp_yumi_i = 1'b1;
        send(1'b0, 40'h100, 64'h0, 16'h0505, 64'h0);
        send(1'b0, 40'h1c0, 64'h0, 16'h0506, 64'h0);
        wait_drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        test_reset();
        test_write_read();
        test_len();
        test_start_done();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout sim time exceeded limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
